// File: rtl/led_pattern_ctrl_pkg.sv
// Shared types and helpers for the LED bar controller: mode encoding,
// mode sequencing and the start pattern loaded on each mode change.
package led_pkg;

    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        FILL   = 2'd1,
        BLINK  = 2'd2
    } mode_t;

    // Widest LED bus the pattern helpers can describe; callers truncate.
    localparam int MAX_BITS = 64;

    typedef logic [MAX_BITS-1:0] pat_t;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            BOUNCE:  return FILL;
            FILL:    return BLINK;
            default: return BOUNCE;
        endcase
    endfunction

    function automatic pat_t all_ones(input int bits);
        pat_t p;
        p = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < bits) p[i] = 1'b1;
        end
        return p;
    endfunction

    function automatic pat_t start_pattern(input mode_t m, input int bits);
        case (m)
            BOUNCE:  return pat_t'(1);
            FILL:    return '0;
            default: return all_ones(bits);
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Button/speed inputs and LED/status outputs of the LED bar controller.
interface led_pattern_ctrl_if
    import led_pkg::*;
#(
    parameter int BITS = 10
);
    logic            btn_mode;
    logic            btn_pause;
    logic [1:0]      speed;
    logic [BITS-1:0] leds;
    mode_t           mode;
    logic            running;

    modport master (
        output btn_mode, btn_pause, speed,
        input  leds, mode, running
    );

    modport slave (
        input  btn_mode, btn_pause, speed,
        output leds, mode, running
    );
endinterface

// File: rtl/led_pattern_ctrl_step_tick.sv
// Base-tick prescaler plus step counter; step is a one-cycle pulse valid
// in the cycle whose edge should advance the pattern.
module step_tick #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       step
);
    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_reg;
    logic [1:0]    cnt_reg;
    logic          tick;

    assign tick = en && !clr && (presc_reg == LAST);
    // A counter left above a freshly lowered speed steps immediately.
    assign step = tick && (cnt_reg >= speed);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            presc_reg <= '0;
            cnt_reg   <= '0;
        end else if (en) begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                cnt_reg <= step ? 2'd0 : cnt_reg + 2'd1;
            end
        end
    end
endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bar sequencer: bounce, fill/drain and blink patterns with mode
// cycling and run/pause from debounced pushbuttons.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int BITS     = 10,
    parameter int TICK_DIV = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    led_pattern_ctrl_if.slave bus
);
    logic [BITS-1:0] leds_reg;
    mode_t           mode_reg;
    logic            running_reg;
    logic            dir_reg;    // 0 = left, 1 = right
    logic            phase_reg;  // 0 = fill, 1 = drain

    logic [1:0]      btn_vec;
    logic [1:0]      press;
    logic            mode_press;
    logic            pause_press;
    logic            step;

    pat_t            start_full;
    logic [BITS-1:0] start_pat;
    logic [BITS-1:0] bounce_next;
    logic [BITS-1:0] fill_next;

    assign btn_vec = {bus.btn_pause, bus.btn_mode};

    // History resets high so a button held through reset is not a press;
    // the press is registered, so it acts one edge after it is first seen.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            logic q_reg;
            logic p_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= 1'b1;
                    p_reg <= 1'b0;
                end else begin
                    q_reg <= btn_vec[gi];
                    p_reg <= btn_vec[gi] & ~q_reg;
                end
            end
            assign press[gi] = p_reg;
        end
    endgenerate

    assign mode_press  = press[0];
    assign pause_press = press[1];

    step_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_step_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (running_reg),
        .clr   (mode_press),
        .speed (bus.speed),
        .step  (step)
    );

    assign start_full  = start_pattern(next_mode(mode_reg), BITS);
    assign start_pat   = start_full[BITS-1:0];
    assign bounce_next = dir_reg ? (leds_reg >> 1) : (leds_reg << 1);
    assign fill_next   = {leds_reg[BITS-2:0], ~phase_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_reg    <= BITS'(1);
            mode_reg    <= BOUNCE;
            running_reg <= 1'b1;
            dir_reg     <= 1'b0;
            phase_reg   <= 1'b0;
        end else begin
            if (pause_press) begin
                running_reg <= ~running_reg;
            end
            if (mode_press) begin
                mode_reg  <= next_mode(mode_reg);
                leds_reg  <= start_pat;
                dir_reg   <= 1'b0;
                phase_reg <= 1'b0;
            end else if (step) begin
                case (mode_reg)
                    BOUNCE: begin
                        leds_reg <= bounce_next;
                        if (!dir_reg && leds_reg[BITS-2]) dir_reg <= 1'b1;
                        if (dir_reg && leds_reg[1])       dir_reg <= 1'b0;
                    end
                    FILL: begin
                        leds_reg <= fill_next;
                        if (!phase_reg && (&fill_next))    phase_reg <= 1'b1;
                        if (phase_reg && (fill_next == '0)) phase_reg <= 1'b0;
                    end
                    default: begin
                        leds_reg <= ~leds_reg;
                    end
                endcase
            end
        end
    end

    assign bus.leds    = leds_reg;
    assign bus.mode    = mode_reg;
    assign bus.running = running_reg;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with BITS=10, TICK_DIV=4.
module tb_led_pattern_ctrl;
    import led_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    led_pattern_ctrl_if #(.BITS(10)) bus ();

    led_pattern_ctrl #(
        .BITS     (10),
        .TICK_DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [31:0] l, input logic [31:0] m,
                             input logic [31:0] r);
        check({tag, "_leds"}, 32'(bus.leds), l);
        check({tag, "_mode"}, 32'(bus.mode), m);
        check({tag, "_run"},  32'(bus.running), r);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.btn_mode  = 1'b0;
        bus.btn_pause = 1'b0;
        bus.speed     = 2'd0;
        cyc(2);
        rst = 1'b0;
        check_all("reset", 32'h001, 0, 1);

        // speed 0: one step every 4 clocks
        cyc(3);  check("pre_step1", 32'(bus.leds), 32'h001);
        cyc(1);  check("step1",     32'(bus.leds), 32'h002);
        cyc(32); check("step9",     32'(bus.leds), 32'h200);
        cyc(4);  check("step10",    32'(bus.leds), 32'h100);
        cyc(32); check("step18",    32'(bus.leds), 32'h001);

        // speed 3: one step every 16 clocks
        bus.speed = 2'd3;
        cyc(15); check("spd3_hold1", 32'(bus.leds), 32'h001);
        cyc(1);  check("spd3_step1", 32'(bus.leds), 32'h002);
        cyc(15); check("spd3_hold2", 32'(bus.leds), 32'h002);
        cyc(1);  check("spd3_step2", 32'(bus.leds), 32'h004);
        cyc(9);
        bus.speed = 2'd0;
        cyc(2);  check("spd_drop_hold", 32'(bus.leds), 32'h004);
        cyc(1);  check("spd_drop_step", 32'(bus.leds), 32'h008);

        // mode press into FILL
        bus.btn_mode = 1'b1;
        cyc(1);  check_all("mode_lat", 32'h008, 0, 1);
        cyc(1);  check_all("to_fill", 32'h000, 1, 1);
        bus.btn_mode = 1'b0;
        cyc(3);  check("fill_hold",   32'(bus.leds), 32'h000);
        cyc(1);  check("fill_s1",     32'(bus.leds), 32'h001);
        cyc(4);  check("fill_s2",     32'(bus.leds), 32'h003);
        cyc(32); check("fill_s10",    32'(bus.leds), 32'h3FF);
        cyc(4);  check("fill_s11",    32'(bus.leds), 32'h3FE);
        cyc(36); check("fill_s20",    32'(bus.leds), 32'h000);
        cyc(4);  check("fill_s21",    32'(bus.leds), 32'h001);

        // pause two clocks into a tick period, then resume
        bus.btn_pause = 1'b1;
        cyc(1);  check("pause_lat",   32'(bus.running), 32'd1);
        cyc(1);  check("paused",      32'(bus.running), 32'd0);
        bus.btn_pause = 1'b0;
        cyc(100); check("pause_hold", 32'(bus.leds), 32'h001);
        bus.btn_pause = 1'b1;
        cyc(1);  check("resume_lat",  32'(bus.running), 32'd0);
        bus.btn_pause = 1'b0;
        cyc(1);  check_all("resumed", 32'h001, 1, 1);
        cyc(1);  check("resume_hold", 32'(bus.leds), 32'h001);
        cyc(1);  check("resume_step", 32'(bus.leds), 32'h003);

        // mode and pause in the same cycle
        bus.btn_mode  = 1'b1;
        bus.btn_pause = 1'b1;
        cyc(2);  check_all("both", 32'h3FF, 2, 0);
        bus.btn_mode  = 1'b0;
        bus.btn_pause = 1'b0;
        cyc(20); check_all("both_hold", 32'h3FF, 2, 0);

        // reset with mode button held: no press afterwards
        bus.btn_mode = 1'b1;
        rst          = 1'b1;
        cyc(2);
        rst = 1'b0;
        check_all("rst_blink", 32'h001, 0, 1);
        cyc(3);  check_all("held_no_edge", 32'h001, 0, 1);
        bus.btn_mode = 1'b0;
        cyc(1);  check("held_step1", 32'(bus.leds), 32'h002);

        // FILL up to 07F, pause, then reset for one cycle
        bus.btn_mode = 1'b1;
        cyc(2);  check_all("fill2", 32'h000, 1, 1);
        bus.btn_mode = 1'b0;
        cyc(28); check("fill2_s7", 32'(bus.leds), 32'h07F);
        bus.btn_pause = 1'b1;
        cyc(2);  check_all("fill2_pause", 32'h07F, 1, 0);
        bus.btn_pause = 1'b0;
        cyc(10); check("fill2_hold", 32'(bus.leds), 32'h07F);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_all("rst_mid", 32'h001, 0, 1);
        cyc(3);  check("rst_mid_hold", 32'(bus.leds), 32'h001);
        cyc(1);  check("rst_mid_step", 32'(bus.leds), 32'h002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
